button_setreset: RTL



---
 rtl/button_setreset.sv | 68 ++++++
 1 files changed

// File: rtl/button_setreset.sv
// rtl/button_setreset.sv - synchronise, debounce and edge-detect a raw pin into set/reset strobes
// Level mode maps press/release to set/reset; toggle mode alternates set/reset on each press.
module button_setreset #(
  parameter int DEBOUNCE = 16,
  parameter int MODE     = 0,
  parameter int INVERT   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic set,
  output logic reset,
  output logic state
);

  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic          INV      = (INVERT != 0);
  localparam logic          TOGGLE   = (MODE != 0);

  logic          s1;
  logic          s2;
  logic          s;
  logic          tog;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          rise;
  logic          fall;

  // Synchroniser resets to the idle pin level so a held pin after reset reads as a fresh press.
  assign s      = s2 ^ INV;
  assign accept = (s != state) && (cnt == CNT_LAST);
  assign rise   = accept && s;
  assign fall   = accept && !s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= INV;
      s2    <= INV;
      cnt   <= '0;
      state <= 1'b0;
      tog   <= 1'b0;
      set   <= 1'b0;
      reset <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;

      if (s == state) begin
        cnt <= '0;
      end else if (accept) begin
        state <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Strobes land on the same edge as the state change and self-clear one cycle later.
      set   <= TOGGLE ? (rise && !tog) : rise;
      reset <= TOGGLE ? (rise && tog)  : fall;

      if (TOGGLE && rise) begin
        tog <= !tog;
      end
    end
  end

endmodule
